if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction fetch stage of the 5-stage RV32I pipeline; the producer side of the IF→ID interface.
- Fetches each 32-bit instruction as four byte reads over the 8-bit memory-controller port and presents {pc, inst} to decode.
- Obeys the stall and jump/branch redirect that decode returns.
- Holds at most one instruction; no overlap between presenting and fetching.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
ICACHE_DEPTH, 64, lines (words) in the optional I-cache; power of 2, ≥2

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stall_i  in  1  decode cannot accept; hold presented instruction
jump_i  in  1  decode redirect, valid in consume cycle only
jump_addr_i  in  32  redirect target
pc_o  out  32  pc of presented / in-flight instruction
inst_o  out  32  instruction to decode; 32'h0 (bubble) when not valid
inst_valid_o  out  1  inst_o valid this cycle
mem_req_o  out  1  byte read request
mem_addr_o  out  32  byte address
mem_gnt_i  in  1  request accepted this cycle
mem_data_i  in  8  read byte
mem_rvalid_i  in  1  mem_data_i valid; ≥1 cycle after gnt

Behaviour:
- Reset: pc_o=RESET_PC, inst_o=0, inst_valid_o=0, mem_req_o=0, mem_addr_o=0, byte index 0, state REQ. Any outstanding byte is dropped; the memory controller shares rst.
- FSM states:
  - REQ: mem_req_o=1, mem_addr_o=pc+idx; both held stable until mem_gnt_i. On gnt → WAIT.
  - WAIT: mem_req_o=0. On mem_rvalid_i, write byte to inst buffer [8*idx+7:8*idx] (little-endian). If idx<3: idx++ and → REQ. If idx==3: → PRESENT.
  - PRESENT: inst_valid_o=1, inst_o=buffer, pc_o=pc. No memory traffic.
- Latency: with gnt in the same cycle as req and rvalid one cycle later, inst_valid_o rises 8 cycles after entry to REQ idx 0.
- Consume: a cycle with inst_valid_o=1 and stall_i=0.
  - Without jump_i: pc←pc+4, idx←0, → REQ.
  - With jump_i=1: pc←jump_addr_i, idx←0, → REQ.
  - inst_valid_o drops the next cycle.
- Stall: stall_i=1 in PRESENT holds pc_o/inst_o/inst_valid_o unchanged for any duration. stall_i is ignored in REQ/WAIT; fetching continues.
- jump_i is ignored unless consuming; a bubble never redirects.
- Misaligned jump_addr_i is not trapped; bytes are fetched from the given address.
- pc arithmetic is 32-bit wrap: 32'hFFFF_FFFC+4 → 0. mem_addr_o wraps the same way.
- mem_rvalid_i outside WAIT is ignored. mem_gnt_i outside REQ is ignored.
- Reset mid-fetch (any state) returns to REQ idx 0 at RESET_PC on the first cycle rst is low. Partial buffer contents are discarded.
- inst_o is 32'h0 whenever inst_valid_o=0; decode treats opcode 0 as a no-op.

Optional Feature:
- Macro: ICACHE_EN.
- Defined:
  - Direct-mapped I-cache, ICACHE_DEPTH word lines.
  - index=pc[log2(ICACHE_DEPTH)+1:2], tag=pc[31:log2(ICACHE_DEPTH)+2], per-line valid bit cleared by rst.
  - At each fetch start (reset release or consume), the new pc is looked up.
  - Hit: state PRESENT next cycle, inst from cache, no mem_req_o.
  - Miss: normal REQ/WAIT sequence; the line is filled on the 4th rvalid, in parallel with entering PRESENT.
  - No invalidate; self-modifying code is unsupported.
- Undefined: no arrays; every fetch uses memory; behaviour is as above.

Test Plan:
- Reset, RESET_PC=0, memory bytes 0x13,0x05,0x10,0x00 at 0..3, gnt immediate, rvalid +1 → mem_addr_o 0,1,2,3; inst_valid_o=1 at cycle 8 with inst_o=32'h0010_0513, pc_o=0.
- mem_gnt_i withheld 3 cycles on byte 1 → mem_req_o=1 with mem_addr_o=1 held stable throughout; inst_valid_o rises at cycle 11.
- stall_i=1 for 5 cycles while valid → pc_o/inst_o unchanged, mem_req_o=0 throughout. On release, one consume, then mem_addr_o=4 and pc_o=4.
- Consume with jump_i=1, jump_addr_i=32'h100 → next mem_addr_o=32'h100, pc_o=32'h100. A jump_i pulse while inst_valid_o=0 has no effect.
- rst pulsed after byte 2 rvalid → all outputs at reset values next cycle, refetch starts at byte 0 of RESET_PC. pc=32'hFFFF_FFFC consume → pc wraps to 0.
- ICACHE_EN: fetch 0, jump back to 0 → second fetch valid 1 cycle after consume, no mem_req_o. Aliasing address 0+4*ICACHE_DEPTH misses and refills.

Source files
------------

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: RV32I instruction fetch over an 8-bit memory port; optional I-cache under ICACHE_EN
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int          ICACHE_DEPTH = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        jump_i,
   input  logic [31:0] jump_addr_i,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        inst_valid_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_gnt_i,
   input  logic [7:0]  mem_data_i,
   input  logic        mem_rvalid_i
);
   localparam logic [1:0] S_REQ     = 2'd0;
   localparam logic [1:0] S_WAIT    = 2'd1;
   localparam logic [1:0] S_PRESENT = 2'd2;
   if (ICACHE_DEPTH < 2 || (ICACHE_DEPTH & (ICACHE_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("ICACHE_DEPTH must be a power of two >= 2");
   end
   logic [1:0]  state;
   logic [1:0]  idx;
   logic [31:0] pc;
   logic [31:0] ibuf;
   logic [31:0] next_pc;
   logic [31:0] hit_data;
   logic        consume;
   logic        hit;
   assign consume      = state == S_PRESENT && !stall_i;
   assign next_pc      = jump_i ? jump_addr_i : pc + 32'd4;
   assign mem_req_o    = state == S_REQ && !rst;
   assign mem_addr_o   = mem_req_o ? pc + {30'd0, idx} : 32'd0;
   assign inst_valid_o = state == S_PRESENT;
   assign inst_o       = inst_valid_o ? ibuf : 32'd0;
   assign pc_o         = pc;
`ifdef ICACHE_EN
   localparam int IW = $clog2(ICACHE_DEPTH);
   localparam int TW = 30 - IW;
   logic [31:0]             c_data [ICACHE_DEPTH];
   logic [TW-1:0]           c_tag  [ICACHE_DEPTH];
   logic [ICACHE_DEPTH-1:0] c_valid;
   logic [IW-1:0]           l_idx;
   logic [IW-1:0]           f_idx;
   logic                    fill;
   assign l_idx    = next_pc[IW+1:2];
   assign f_idx    = pc[IW+1:2];
   assign hit      = c_valid[l_idx] && c_tag[l_idx] == next_pc[31:IW+2];
   assign hit_data = c_data[l_idx];
   assign fill     = state == S_WAIT && mem_rvalid_i && idx == 2'd3;
   // line valid bits: cleared by reset, set when a missed word completes
   always_ff @(posedge clk) begin
      if (rst) c_valid <= '0;
      else if (fill) c_valid[f_idx] <= 1'b1;
   end
   // line payload: last byte comes straight from the port, the rest from the buffer
   always_ff @(posedge clk) begin
      if (fill) begin
         c_data[f_idx] <= {mem_data_i, ibuf[23:0]};
         c_tag[f_idx]  <= pc[31:IW+2];
      end
   end
`else
   assign hit      = 1'b0;
   assign hit_data = 32'd0;
`endif
   // fetch sequencer: request byte, wait for its data, present the word, then advance or redirect
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_REQ;
         pc    <= RESET_PC;
         idx   <= 2'd0;
         ibuf  <= 32'd0;
      end else if (state == S_REQ) begin
         if (mem_gnt_i) state <= S_WAIT;
      end else if (state == S_WAIT) begin
         if (mem_rvalid_i) begin
            ibuf[{idx, 3'b000} +: 8] <= mem_data_i;
            idx   <= idx + 2'd1;
            state <= idx == 2'd3 ? S_PRESENT : S_REQ;
         end
      end else if (consume) begin
         pc    <= next_pc;
         idx   <= 2'd0;
         state <= hit ? S_PRESENT : S_REQ;
         ibuf  <= hit ? hit_data : ibuf;
      end
   end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: scoreboard bench for if_fetch_unit with a byte-memory responder
module tb_if_fetch_unit;
   localparam int DEPTH = 64;
   logic        clk = 1'b0;
   logic        rst, stall_i, jump_i;
   logic [31:0] jump_addr_i;
   logic [31:0] pc_o, inst_o, mem_addr_o;
   logic        inst_valid_o, mem_req_o, mem_gnt_i, mem_rvalid_i;
   logic [7:0]  mem_data_i;
   int          vectors = 0, miscompares = 0, cyc = 0, present_cnt = 0, present_cyc = 0;
   logic [31:0] exp_addr [$];
   logic [63:0] sb [$];
   int          hold_n = 0;
   logic [31:0] hold_addr = 32'd0;
   logic        pend = 1'b0;
   logic [31:0] pend_addr = 32'd0;
   logic        pv = 1'b0, pcons = 1'b0;
   logic [31:0] ppc = 32'd0, pinst = 32'd0;
`ifdef ICACHE_EN
   logic [29:0] mtag [int];
`endif

   if_fetch_unit #(.RESET_PC(32'h0), .ICACHE_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .jump_i(jump_i), .jump_addr_i(jump_addr_i),
      .pc_o(pc_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
      .mem_data_i(mem_data_i), .mem_rvalid_i(mem_rvalid_i)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [7:0] byte_at(input logic [31:0] a);
      if (a == 32'd0) return 8'h13;
      if (a == 32'd1) return 8'h05;
      if (a == 32'd2) return 8'h10;
      if (a == 32'd3) return 8'h00;
      return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
   endfunction

   function automatic logic [31:0] inst_at(input logic [31:0] a);
      return {byte_at(a + 32'd3), byte_at(a + 32'd2), byte_at(a + 32'd1), byte_at(a)};
   endfunction

   task automatic expect_fetch(input logic [31:0] a, output logic hit);
      hit = 1'b0;
`ifdef ICACHE_EN
      begin
         int ix = int'(a[7:2]);
         hit = mtag.exists(ix) && mtag[ix] == a[31:2];
         if (!hit) mtag[ix] = a[31:2];
      end
`endif
      if (!hit) for (int i = 0; i < 4; i++) exp_addr.push_back(a + 32'(i));
      sb.push_back({a, inst_at(a)});
   endtask

   task automatic model_reset();
`ifdef ICACHE_EN
      mtag.delete();
`endif
   endtask

   task automatic do_consume(input logic j, input logic [31:0] a, output int c);
      @(negedge clk);
      jump_i = j;
      jump_addr_i = a;
      stall_i = 1'b0;
      c = cyc;
      @(negedge clk);
      jump_i = 1'b0;
      stall_i = 1'b1;
      #2;
   endtask

   task automatic wait_present(output int p);
      int  n0 = present_cnt;
      logic got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         #3;
         got = present_cnt != n0;
      end
      check("present_timeout", got, 1);
      p = present_cyc;
   endtask

   // memory responder: grant unless holding, return data the cycle after grant
   always @(negedge clk) begin
      #1;
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
      if (rst) pend = 1'b0;
      else begin
         if (pend) begin
            mem_rvalid_i = 1'b1;
            mem_data_i = byte_at(pend_addr);
         end
         pend = 1'b0;
         if (mem_req_o) begin
            check("req_expected", exp_addr.size() > 0, 1);
            if (exp_addr.size() > 0) begin
               check("mem_addr", mem_addr_o, exp_addr[0]);
               if (hold_n > 0 && mem_addr_o == hold_addr) hold_n--;
               else begin
                  mem_gnt_i = 1'b1;
                  pend = 1'b1;
                  pend_addr = mem_addr_o;
                  void'(exp_addr.pop_front());
               end
            end
         end
      end
   end

   // output monitor: bubbles, stall hold, and scoreboard pop on each new presentation
   always @(negedge clk) begin
      logic [63:0] e;
      #2;
      if (rst) begin
         pv = 1'b0;
         pcons = 1'b0;
      end else begin
         if (!inst_valid_o) check("bubble_inst", inst_o, 0);
         else begin
            check("present_no_req", mem_req_o, 0);
            if (pv && !pcons) begin
               check("stall_pc", pc_o, ppc);
               check("stall_inst", inst_o, pinst);
            end else begin
               check("sb_nonempty", sb.size() > 0, 1);
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  check("present_pc", pc_o, e[63:32]);
                  check("present_inst", inst_o, e[31:0]);
                  present_cnt++;
                  present_cyc = cyc;
               end
            end
         end
         if (pv && !pcons) check("stall_valid", inst_valid_o, 1);
         pv = inst_valid_o;
         pcons = inst_valid_o && !stall_i;
         ppc = pc_o;
         pinst = inst_o;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int   c, p;
      logic h, found;
      rst = 1'b1;
      stall_i = 1'b1;
      jump_i = 1'b0;
      jump_addr_i = 32'd0;
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_data_i = 8'd0;
      repeat (3) @(negedge clk);
      #2;
      check("rst_pc", pc_o, 0);
      check("rst_inst", inst_o, 0);
      check("rst_valid", inst_valid_o, 0);
      check("rst_req", mem_req_o, 0);
      check("rst_addr", mem_addr_o, 0);
      expect_fetch(32'h0, h);
      @(negedge clk);
      rst = 1'b0;
      c = cyc;
      wait_present(p);
      check("lat_first", p - c, 8);
      repeat (5) @(negedge clk);
      hold_addr = 32'd5;
      hold_n = 3;
      expect_fetch(32'h4, h);
      do_consume(1'b0, 32'h0, c);
      check("pc_after_consume", pc_o, 32'h4);
      check("addr_after_consume", mem_addr_o, 32'h4);
      wait_present(p);
      check("lat_gnt_hold", p - c, 12);
      check("hold_used", hold_n, 0);
      expect_fetch(32'h100, h);
      do_consume(1'b1, 32'h100, c);
      check("pc_after_jump", pc_o, 32'h100);
      check("addr_after_jump", mem_addr_o, 32'h100);
      repeat (2) @(negedge clk);
      jump_i = 1'b1;
      jump_addr_i = 32'h200;
      stall_i = 1'b0;
      @(negedge clk);
      jump_i = 1'b0;
      stall_i = 1'b1;
      wait_present(p);
      check("lat_jump", p - c, 9);
      for (int i = 0; i < 3; i++) exp_addr.push_back(32'h104 + 32'(i));
      do_consume(1'b0, 32'h0, c);
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk);
         found = mem_req_o && mem_addr_o == 32'h107;
      end
      check("reached_byte3", found, 1);
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      #2;
      check("mid_rst_pc", pc_o, 0);
      check("mid_rst_inst", inst_o, 0);
      check("mid_rst_valid", inst_valid_o, 0);
      check("mid_rst_req", mem_req_o, 0);
      check("mid_rst_addr", mem_addr_o, 0);
      expect_fetch(32'h0, h);
      @(negedge clk);
      rst = 1'b0;
      c = cyc;
      wait_present(p);
      check("lat_refetch", p - c, 8);
      expect_fetch(32'hFFFF_FFFC, h);
      do_consume(1'b1, 32'hFFFF_FFFC, c);
      wait_present(p);
      expect_fetch(32'h0, h);
      do_consume(1'b0, 32'h0, c);
      check("pc_wrap", pc_o, 0);
      wait_present(p);
      check("lat_wrap", p - c, h ? 1 : 9);
      expect_fetch(32'h0, h);
      do_consume(1'b1, 32'h0, c);
      wait_present(p);
      check("lat_rejump", p - c, h ? 1 : 9);
      expect_fetch(32'(4 * DEPTH), h);
      do_consume(1'b1, 32'(4 * DEPTH), c);
      wait_present(p);
      check("lat_alias", p - c, h ? 1 : 9);
      expect_fetch(32'h0, h);
      do_consume(1'b1, 32'h0, c);
      wait_present(p);
      check("lat_evicted", p - c, h ? 1 : 9);
      repeat (3) @(negedge clk);
      check("sb_drained", sb.size(), 0);
      check("addr_drained", exp_addr.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
